// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
// Holds the default pattern, the mode encodings and the state-width function.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

    localparam bit OVERLAP_OFF = 1'b0;
    localparam bit OVERLAP_ON  = 1'b1;

    localparam bit MOORE_OUT = 1'b0;
    localparam bit MEALY_OUT = 1'b1;

    // Smallest w with 2**w >= n, used to size the matched-prefix state.
    function automatic int stateWidth(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating up-counter with synchronous clear and reset.
// Reset beats clear, clear beats increment; the count sticks at all ones.
module seq_det_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: tracks the longest matched pattern prefix per bit,
// flags each full match (Moore or Mealy timed) and counts matches.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter bit               OVERLAP = OVERLAP_ON,
    parameter bit               MEALY   = MOORE_OUT,
    parameter int               CNT_W   = 8,
    localparam int              SW      = stateWidth(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic             din_i,
    input  logic             clear_i,
    output logic             match_o,
    output logic [CNT_W-1:0] count_o,
    output logic [SW-1:0]    state_o
);

    typedef enum logic [1:0] {
        PHASE_RESET,
        PHASE_RUN
    } phase_t;

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [PAT_W-2:0] hist_q;
    logic [PAT_W-2:0] hist_d;
    logic [SW-1:0]    histLen_q;
    logic [SW-1:0]    histLen_d;
    logic             match_q;
    phase_t           phase_q;

    logic [PAT_W-1:0] window;
    logic [PAT_W:1]   prefixHit;
    logic             hit;

    // Newest bit sits at the LSB, so window[k-1:0] is the last k accepted bits.
    assign window = {hist_q, din_i};
    assign hist_d = window[PAT_W-2:0];

    for (genvar k = 1; k <= PAT_W; k++) begin : g_prefix
        if (k == 1) begin : g_first
            assign prefixHit[k] = (window[0] == PATTERN[PAT_W-1]);
        end else begin : g_longer
            assign prefixHit[k] = (histLen_q >= SW'(k - 1)) &&
                                  (window[k-1:0] == PATTERN[PAT_W-1 -: k]);
        end
    end

    always_comb begin
        state_d = '0;
        for (int i = 1; i <= PAT_W; i++) begin
            if (prefixHit[i]) begin
                state_d = SW'(i);
            end
        end
    end

    assign hit = in_valid_i && (state_d == SW'(PAT_W));

    // Without overlap a match empties the history so the next bit starts fresh.
    always_comb begin
        histLen_d = histLen_q;
        if (hit && !OVERLAP) begin
            histLen_d = '0;
        end else if (histLen_q < SW'(PAT_W - 1)) begin
            histLen_d = histLen_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PHASE_RESET;
            state_q   <= '0;
            hist_q    <= '0;
            histLen_q <= '0;
            match_q   <= 1'b0;
        end else begin
            phase_q <= PHASE_RUN;
            match_q <= hit;
            if (in_valid_i) begin
                state_q   <= state_d;
                hist_q    <= hist_d;
                histLen_q <= histLen_d;
            end
        end
    end

    assign match_o = MEALY ? hit : match_q;
    assign state_o = state_q;

    seq_det_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (hit),
        .clear_i (clear_i),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: four configurations share one input stream
// and each is checked against hand-computed expectations.
module tb_seq_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic inValid = 1'b0;
    logic din     = 1'b0;
    logic clear   = 1'b0;

    logic       matchA, matchB, matchC, matchD;
    logic [7:0] countA, countB, countC;
    logic [1:0] countD;
    logic [2:0] stateA, stateB, stateC, stateD;

    int vecCount  = 0;
    int missCount = 0;

    // A: overlap/Moore, B: no-overlap/Moore, C: overlap/Mealy, D: no-overlap/2-bit count
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8)) dutA (
        .clk(clk), .reset(reset), .in_valid_i(inValid), .din_i(din), .clear_i(clear),
        .match_o(matchA), .count_o(countA), .state_o(stateA));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b0), .CNT_W(8)) dutB (
        .clk(clk), .reset(reset), .in_valid_i(inValid), .din_i(din), .clear_i(clear),
        .match_o(matchB), .count_o(countB), .state_o(stateB));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8)) dutC (
        .clk(clk), .reset(reset), .in_valid_i(inValid), .din_i(din), .clear_i(clear),
        .match_o(matchC), .count_o(countC), .state_o(stateC));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b0), .CNT_W(2)) dutD (
        .clk(clk), .reset(reset), .in_valid_i(inValid), .din_i(din), .clear_i(clear),
        .match_o(matchD), .count_o(countD), .state_o(stateD));

    int expStA  [7] = '{1, 2, 3, 4, 2, 3, 4};
    int expStB  [7] = '{1, 2, 3, 4, 0, 1, 1};
    int expMoA  [7] = '{0, 0, 0, 1, 0, 0, 1};
    int expMoB  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int expCntA [7] = '{0, 0, 0, 1, 1, 1, 2};
    int expCntB [7] = '{0, 0, 0, 1, 1, 1, 1};
    int expSatD [6] = '{1, 2, 3, 3, 3, 0};

    logic [6:0] stream  = 7'b1011011;
    logic [3:0] pattern = 4'b1011;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; Mealy outputs can be sampled 1 time unit later.
    task automatic applyStimulus(input logic v, input logic d, input logic c, input logic r);
        @(negedge clk);
        reset   = r;
        inValid = v;
        din     = d;
        clear   = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " stateA"}, 16'(stateA), 16'd0);
        checkOutput({tag, " stateB"}, 16'(stateB), 16'd0);
        checkOutput({tag, " matchA"}, 16'(matchA), 16'd0);
        checkOutput({tag, " countA"}, 16'(countA), 16'd0);
        checkOutput({tag, " countD"}, 16'(countD), 16'd0);
    endtask

    initial begin
        $display("[TB] seq_detector directed test start");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkResetState("reset");

        // Stream 1011011 into all four configurations
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, stream[6-i], 1'b0, 1'b0);
            checkOutput($sformatf("s1 mealyC b%0d", i + 1), 16'(matchC), 16'(expMoA[i]));
            tick();
            checkOutput($sformatf("s1 stateA b%0d", i + 1), 16'(stateA), 16'(expStA[i]));
            checkOutput($sformatf("s1 matchA b%0d", i + 1), 16'(matchA), 16'(expMoA[i]));
            checkOutput($sformatf("s1 countA b%0d", i + 1), 16'(countA), 16'(expCntA[i]));
            checkOutput($sformatf("s1 stateB b%0d", i + 1), 16'(stateB), 16'(expStB[i]));
            checkOutput($sformatf("s1 matchB b%0d", i + 1), 16'(matchB), 16'(expMoB[i]));
            checkOutput($sformatf("s1 countB b%0d", i + 1), 16'(countB), 16'(expCntB[i]));
            checkOutput($sformatf("s1 stateC b%0d", i + 1), 16'(stateC), 16'(expStA[i]));
            checkOutput($sformatf("s1 countC b%0d", i + 1), 16'(countC), 16'(expCntA[i]));
            checkOutput($sformatf("s1 stateD b%0d", i + 1), 16'(stateD), 16'(expStB[i]));
            checkOutput($sformatf("s1 countD b%0d", i + 1), 16'(countD), 16'(expCntB[i]));
        end

        // Bits separated by invalid cycles carrying a misleading din of 1
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkResetState("gap reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pattern[3-i], 1'b0, 1'b0);
            checkOutput($sformatf("gap mealyC b%0d", i + 1), 16'(matchC), 16'(i == 3));
            tick();
            checkOutput($sformatf("gap stateA b%0d", i + 1), 16'(stateA), 16'(i + 1));
            checkOutput($sformatf("gap matchA b%0d", i + 1), 16'(matchA), 16'(i == 3));
            for (int j = 0; j < 3; j++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                checkOutput($sformatf("gap idle mealyC b%0d", i + 1), 16'(matchC), 16'd0);
                tick();
                checkOutput($sformatf("gap hold stateA b%0d", i + 1), 16'(stateA), 16'(i + 1));
                checkOutput($sformatf("gap idle matchA b%0d", i + 1), 16'(matchA), 16'd0);
            end
        end
        checkOutput("gap countA", 16'(countA), 16'd1);
        checkOutput("gap countC", 16'(countC), 16'd1);

        // Six back-to-back patterns: 2-bit counter saturates, then clear meets a hit
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkResetState("sat reset");
        for (int g = 0; g < 6; g++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(1'b1, pattern[3-b], (g == 5) && (b == 3), 1'b0);
                tick();
            end
            checkOutput($sformatf("sat countD g%0d", g + 1), 16'(countD), 16'(expSatD[g]));
            checkOutput($sformatf("sat matchD g%0d", g + 1), 16'(matchD), 16'd1);
            checkOutput($sformatf("sat stateD g%0d", g + 1), 16'(stateD), 16'd4);
            checkOutput($sformatf("sat countA g%0d", g + 1), 16'(countA),
                        16'((g == 5) ? 0 : g + 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sat post clear countD", 16'(countD), 16'd0);
        checkOutput("sat post matchD", 16'(matchD), 16'd0);

        // Reset mid-pattern, with a would-be completing bit present during reset
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, pattern[3-i], 1'b0, 1'b0);
            tick();
        end
        checkOutput("mid stateA before reset", 16'(stateA), 16'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("mid stateA in reset", 16'(stateA), 16'd0);
        checkOutput("mid matchA in reset", 16'(matchA), 16'd0);
        checkOutput("mid countA in reset", 16'(countA), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mid stateA after", 16'(stateA), 16'd1);
        checkOutput("mid matchA after", 16'(matchA), 16'd0);
        checkOutput("mid countA after", 16'(countA), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mid matchA idle", 16'(matchA), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
